uart_transmitter: RTL and testbench
===================================

Name: uart_transmitter

Overview:
Serialises one parallel word per request onto a UART tx line as start bit, WORD_BITS data bits LSB first, optional parity bit, then stop bit(s). Bit timing comes from an external oversampling tick, baud_i, driven by the shared baud_generator. This is the same tick that drives uart_receiver, so one baud generator serves both directions. It is the transmit counterpart of uart_receiver, and tx_o can be looped straight into rx_i.

Parameters:
WORD_BITS, 8, data bits per frame.
SAMPLE_TICKS, 16, baud_i ticks per bit period; must match uart_receiver.
STOP_TICKS, 16, baud_i ticks in the stop period (16/24/32 = 1/1.5/2 stop bits); must be >= SAMPLE_TICKS.
PARITY_EN, 0, 1 = insert parity bit after the data bits.
PARITY_ODD, 0, 0 = even parity, 1 = odd parity; ignored when PARITY_EN = 0.

Ports:
clk_i  input  1  system clock, all logic on rising edge
reset_i  input  1  synchronous, active-low reset
start_i  input  1  request to send data_i; sampled only in IDLE
data_i  input  WORD_BITS  word to send; latched on accepted start_i
baud_i  input  1  one-cycle oversample tick from baud_generator
tx_o  output  1  serial line, registered, idle high
busy_o  output  1  high while a frame is in progress (state != IDLE)
done_o  output  1  one-cycle pulse when the stop period completes

Behaviour:
- Reset (reset_i = 0 at posedge): state = IDLE, tx_o = 1, busy_o = 0, done_o = 0, tick/bit counters = 0, shift register = 0. Reset takes priority over all other inputs, including mid-frame: next cycle tx_o = 1 and no done_o is produced.
- States: IDLE, START, DATA, PARITY, STOP.
- All outputs are registered. done_o defaults to 0 every cycle.
- tick_cnt width = $clog2(STOP_TICKS). bit_cnt width = $clog2(WORD_BITS).
- IDLE:
  - tx_o = 1; baud_i is ignored.
  - On start_i = 1: latch data_i into the shift register, compute the parity bit (XOR of data_i, inverted when PARITY_ODD), clear tick_cnt, go to START.
  - From the next cycle: tx_o = 0 and busy_o = 1.
- START:
  - tx_o = 0.
  - Each baud_i increments tick_cnt.
  - On baud_i with tick_cnt = SAMPLE_TICKS-1: clear tick_cnt and bit_cnt, go to DATA, and drive tx_o = shift[0] from the next cycle.
- DATA:
  - tx_o = shift[0].
  - On baud_i with tick_cnt = SAMPLE_TICKS-1: clear tick_cnt and shift right by one.
  - If bit_cnt = WORD_BITS-1, go to PARITY when PARITY_EN, else STOP; otherwise increment bit_cnt.
- PARITY: tx_o = parity bit for one bit period (SAMPLE_TICKS ticks), then go to STOP.
- STOP:
  - tx_o = 1.
  - On baud_i with tick_cnt = STOP_TICKS-1: go to IDLE, done_o = 1 for that one cycle, busy_o = 0 from the same cycle.
- Back-to-back frames: a start_i present in the cycle done_o = 1 is accepted, since the state is already IDLE. This gives a zero-gap next frame.
- start_i while busy_o = 1 is ignored; data_i changes after acceptance have no effect.
- Phase quantisation: baud_i is free-running, so the first START period may be up to one baud_i tick period short. All later bit periods are exactly SAMPLE_TICKS ticks.
- baud_i coincident with state entry counts toward the new state only from the following cycle; the entry cycle tick is not counted.

Decomposition:
- Shared include uart_defs.vh, also used by uart_receiver:
  - state encoding localparams (IDLE/START/DATA/PARITY/STOP);
  - default WORD_BITS and SAMPLE_TICKS.
- Parity calculation is a local function in the module.
- No sub-module. The baud_generator is instantiated by the parent, not inside uart_transmitter.

Test Plan:
Common setup: 100 MHz clock, baud_generator M = 651 (9600 baud x16), tx_o looped to uart_receiver rx_i.
1. Single byte: send 0x55 with default parameters.
   -> tx_o is low for 16 ticks, then 1,0,1,0,1,0,1,0 each for 16 ticks, then high for 16 ticks.
   -> done_o pulses once, busy_o then falls; the receiver reports ready with data 0x55.
2. Back-to-back: send 0xA5, then assert start_i with 0x3C in the done_o cycle.
   -> The second start bit begins the cycle after done_o.
   -> The receiver gets 0xA5 then 0x3C, with two done_o pulses.
3. Ignore while busy: assert start_i with 0xFF mid-frame while sending 0x12.
   -> The frame on the line is still 0x12 and exactly one done_o is produced.
4. Reset mid-frame: pull reset_i low during DATA bit 3.
   -> Next cycle tx_o = 1, busy_o = 0, done_o stays 0.
   -> A subsequent send of 0x81 is received correctly.
5. Parity: with PARITY_EN = 1, send 0x07.
   -> PARITY_ODD = 0: parity bit = 1.
   -> PARITY_ODD = 1: parity bit = 0.
   -> Frame length is 11 bit periods.
6. Stop length: with STOP_TICKS = 32, send 0x00.
   -> tx_o is high for 32 baud ticks before done_o.
   -> start_i is not accepted earlier than that.

Source files
------------

// File: rtl/uart_transmitter_pkg.sv
// Shared UART definitions: FSM state encoding and default frame geometry,
// common to the transmitter and receiver.
package uart_transmitter_pkg;

    localparam logic [2:0] StIdle   = 3'd0;
    localparam logic [2:0] StStart  = 3'd1;
    localparam logic [2:0] StData   = 3'd2;
    localparam logic [2:0] StParity = 3'd3;
    localparam logic [2:0] StStop   = 3'd4;

    localparam int unsigned DEFAULT_WORD_BITS    = 8;
    localparam int unsigned DEFAULT_SAMPLE_TICKS = 16;

endpackage

// File: rtl/uart_transmitter.sv
// UART transmitter: start bit, LSB-first data, optional parity, stop period,
// paced by the shared oversampling tick baud_i.
module uart_transmitter
    import uart_transmitter_pkg::*;
#(
    parameter int unsigned WORD_BITS    = DEFAULT_WORD_BITS,
    parameter int unsigned SAMPLE_TICKS = DEFAULT_SAMPLE_TICKS,
    parameter int unsigned STOP_TICKS   = 16,
    parameter int unsigned PARITY_EN    = 0,
    parameter int unsigned PARITY_ODD   = 0
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 start_i,
    input  logic [WORD_BITS-1:0] data_i,
    input  logic                 baud_i,
    output logic                 tx_o,
    output logic                 busy_o,
    output logic                 done_o
);

    localparam int unsigned TickW = (STOP_TICKS > 1) ? $clog2(STOP_TICKS) : 1;
    localparam int unsigned BitW  = (WORD_BITS > 1) ? $clog2(WORD_BITS) : 1;

    localparam logic [TickW-1:0] SampleLast = TickW'(SAMPLE_TICKS - 1);
    localparam logic [TickW-1:0] StopLast   = TickW'(STOP_TICKS - 1);
    localparam logic [BitW-1:0]  WordLast   = BitW'(WORD_BITS - 1);

    function automatic logic calc_parity(input logic [WORD_BITS-1:0] word);
        return (^word) ^ (PARITY_ODD != 0);
    endfunction

    logic [2:0]           state_q, state_d;
    logic [TickW-1:0]     tick_q, tick_d;
    logic [BitW-1:0]      bit_q, bit_d;
    logic [WORD_BITS-1:0] shift_q, shift_d;
    logic                 par_q, par_d;
    logic                 tx_q, tx_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;

    // tx_d is the line level for the state being entered, so tx_o is registered
    // yet changes in the same cycle as the state.
    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        par_d   = par_q;
        tx_d    = tx_q;
        done_d  = 1'b0;

        case (state_q)
            StIdle: begin
                tx_d = 1'b1;
                if (start_i) begin
                    shift_d = data_i;
                    par_d   = calc_parity(data_i);
                    tick_d  = '0;
                    state_d = StStart;
                    tx_d    = 1'b0;
                end
            end
            StStart: begin
                if (baud_i) begin
                    if (tick_q == SampleLast) begin
                        tick_d  = '0;
                        bit_d   = '0;
                        state_d = StData;
                        tx_d    = shift_q[0];
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
            end
            StData: begin
                if (baud_i) begin
                    if (tick_q == SampleLast) begin
                        tick_d  = '0;
                        shift_d = shift_q >> 1;
                        if (bit_q == WordLast) begin
                            if (PARITY_EN != 0) begin
                                state_d = StParity;
                                tx_d    = par_q;
                            end else begin
                                state_d = StStop;
                                tx_d    = 1'b1;
                            end
                        end else begin
                            bit_d = bit_q + 1'b1;
                            tx_d  = shift_d[0];
                        end
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
            end
            StParity: begin
                if (baud_i) begin
                    if (tick_q == SampleLast) begin
                        tick_d  = '0;
                        state_d = StStop;
                        tx_d    = 1'b1;
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
            end
            StStop: begin
                if (baud_i) begin
                    if (tick_q == StopLast) begin
                        tick_d  = '0;
                        state_d = StIdle;
                        done_d  = 1'b1;
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = StIdle;
                tx_d    = 1'b1;
            end
        endcase

        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            state_q <= StIdle;
            tick_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign tx_o   = tx_q;
    assign busy_o = busy_q;
    assign done_o = done_q;

endmodule

// File: tb/tb_uart_transmitter.sv
// Self-checking bench for uart_transmitter: three parameterisations, line
// captured once per baud tick and compared with an expanded frame model.
module tb_uart_transmitter;

    localparam int Div    = 4;
    localparam int Budget = 3000;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       baud = 1'b0;
    int         div_cnt = 0;
    logic [7:0] data_r = 8'h00;
    logic       start_r [3];
    logic       tx_w [3];
    logic       busy_w [3];
    logic       done_w [3];

    int n_checks = 0;
    int n_pass = 0;

    logic cap[$];
    logic exp_q[$];
    bit   got_done;
    logic first_busy, first_tx;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        div_cnt <= (div_cnt == Div - 1) ? 0 : div_cnt + 1;
        baud    <= (div_cnt == Div - 1);
    end

    uart_transmitter u_dut0 (
        .clk_i(clk), .reset_i(rst_n), .start_i(start_r[0]), .data_i(data_r),
        .baud_i(baud), .tx_o(tx_w[0]), .busy_o(busy_w[0]), .done_o(done_w[0])
    );
    uart_transmitter #(.PARITY_EN(1), .PARITY_ODD(0), .STOP_TICKS(32)) u_dut1 (
        .clk_i(clk), .reset_i(rst_n), .start_i(start_r[1]), .data_i(data_r),
        .baud_i(baud), .tx_o(tx_w[1]), .busy_o(busy_w[1]), .done_o(done_w[1])
    );
    uart_transmitter #(.PARITY_EN(1), .PARITY_ODD(1)) u_dut2 (
        .clk_i(clk), .reset_i(rst_n), .start_i(start_r[2]), .data_i(data_r),
        .baud_i(baud), .tx_o(tx_w[2]), .busy_o(busy_w[2]), .done_o(done_w[2])
    );

    function automatic int p_en(input int d);
        return (d == 0) ? 0 : 1;
    endfunction

    function automatic int p_odd(input int d);
        return (d == 2) ? 1 : 0;
    endfunction

    function automatic int stop_len(input int d);
        return (d == 1) ? 32 : 16;
    endfunction

    // Expected line level at every baud tick of the frame.
    task automatic build_exp(input int d, input logic [7:0] v);
        logic par;
        exp_q.delete();
        repeat (16) exp_q.push_back(1'b0);
        for (int i = 0; i < 8; i++) repeat (16) exp_q.push_back(v[i]);
        if (p_en(d) != 0) begin
            par = ((^v) != (p_odd(d) != 0));
            repeat (16) exp_q.push_back(par);
        end
        repeat (stop_len(d)) exp_q.push_back(1'b1);
    endtask

    function automatic int frame_diff();
        if (cap.size() != exp_q.size()) return -2;
        foreach (cap[i]) if (cap[i] !== exp_q[i]) return i;
        return -1;
    endfunction

    task automatic kick(input int d, input logic [7:0] v);
        @(negedge clk);
        data_r = v;
        start_r[d] = 1'b1;
    endtask

    task automatic collect(input int d, input int poke_at, input logic [7:0] poke_v,
                           input bit chain, input logic [7:0] chain_v);
        int pa;
        pa = poke_at;
        cap.delete();
        got_done = 1'b0;
        for (int c = 0; c < Budget && !got_done; c++) begin
            @(negedge clk);
            start_r[d] = 1'b0;
            data_r = 8'($urandom);
            if (c == 0) begin
                first_busy = busy_w[d];
                first_tx = tx_w[d];
            end
            if (baud && busy_w[d]) cap.push_back(tx_w[d]);
            if (done_w[d]) begin
                got_done = 1'b1;
                if (chain) begin
                    data_r = chain_v;
                    start_r[d] = 1'b1;
                end
            end else if (pa >= 0 && cap.size() >= pa) begin
                start_r[d] = 1'b1;
                data_r = poke_v;
                pa = -1;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            n_checks++;
            if (tx_w[d] !== 1'b1 || busy_w[d] !== 1'b0 || done_w[d] !== 1'b0)
                $display("FAIL reset_state dut%0d: tx/busy/done %b%b%b want 100",
                         d, tx_w[d], busy_w[d], done_w[d]);
            else n_pass++;
        end
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        int df;
        build_exp(0, 8'h55);
        kick(0, 8'h55);
        collect(0, -1, 8'h00, 1'b0, 8'h00);
        df = frame_diff();
        n_checks++;
        if (!got_done) $display("FAIL single_done: no done_o within budget, want one pulse");
        else n_pass++;
        n_checks++;
        if (df !== -1) $display("FAIL single_frame: diff %0d len %0d, want -1 len %0d",
                                df, cap.size(), exp_q.size());
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (done_w[0] !== 1'b0 || busy_w[0] !== 1'b0)
            $display("FAIL single_after: done/busy %b%b want 00", done_w[0], busy_w[0]);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        int df;
        build_exp(0, 8'hA5);
        kick(0, 8'hA5);
        collect(0, -1, 8'h00, 1'b1, 8'h3C);
        df = frame_diff();
        n_checks++;
        if (!got_done || df !== -1)
            $display("FAIL b2b_first: done %b diff %0d, want 1 and -1", got_done, df);
        else n_pass++;
        build_exp(0, 8'h3C);
        collect(0, -1, 8'h00, 1'b0, 8'h00);
        n_checks++;
        if (first_busy !== 1'b1 || first_tx !== 1'b0)
            $display("FAIL b2b_gap: busy/tx after done %b%b want 10", first_busy, first_tx);
        else n_pass++;
        df = frame_diff();
        n_checks++;
        if (!got_done || df !== -1)
            $display("FAIL b2b_second: done %b diff %0d, want 1 and -1", got_done, df);
        else n_pass++;
    endtask

    task automatic test_ignore_busy();
        int df, spur;
        build_exp(0, 8'h12);
        kick(0, 8'h12);
        collect(0, 40, 8'hFF, 1'b0, 8'h00);
        df = frame_diff();
        n_checks++;
        if (!got_done || df !== -1)
            $display("FAIL ignore_frame: done %b diff %0d, want 1 and -1", got_done, df);
        else n_pass++;
        spur = 0;
        repeat (300) begin
            @(negedge clk);
            if (done_w[0] || busy_w[0]) spur++;
        end
        n_checks++;
        if (spur != 0) $display("FAIL ignore_extra: %0d busy/done cycles, want 0", spur);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        int n, spur, df;
        bit hit;
        kick(0, 8'hC3);
        n = 0;
        hit = 1'b0;
        for (int c = 0; c < Budget && !hit; c++) begin
            @(negedge clk);
            start_r[0] = 1'b0;
            if (baud && busy_w[0]) n++;
            if (n >= 72) hit = 1'b1;
        end
        n_checks++;
        if (!hit) $display("FAIL rstmid_reach: %0d ticks seen, want 72", n);
        else n_pass++;
        rst_n = 1'b0;
        @(negedge clk);
        n_checks++;
        if (tx_w[0] !== 1'b1 || busy_w[0] !== 1'b0 || done_w[0] !== 1'b0)
            $display("FAIL rstmid_state: tx/busy/done %b%b%b want 100",
                     tx_w[0], busy_w[0], done_w[0]);
        else n_pass++;
        rst_n = 1'b1;
        spur = 0;
        repeat (300) begin
            @(negedge clk);
            if (done_w[0] || busy_w[0] || tx_w[0] !== 1'b1) spur++;
        end
        n_checks++;
        if (spur != 0) $display("FAIL rstmid_quiet: %0d active cycles, want 0", spur);
        else n_pass++;
        build_exp(0, 8'h81);
        kick(0, 8'h81);
        collect(0, -1, 8'h00, 1'b0, 8'h00);
        df = frame_diff();
        n_checks++;
        if (!got_done || df !== -1)
            $display("FAIL rstmid_resend: done %b diff %0d, want 1 and -1", got_done, df);
        else n_pass++;
    endtask

    task automatic test_parity();
        int df;
        for (int d = 1; d < 3; d++) begin
            build_exp(d, 8'h07);
            kick(d, 8'h07);
            collect(d, -1, 8'h00, 1'b0, 8'h00);
            df = frame_diff();
            n_checks++;
            if (!got_done || df !== -1)
                $display("FAIL parity_frame dut%0d: done %b diff %0d, want 1 and -1",
                         d, got_done, df);
            else n_pass++;
            n_checks++;
            if (cap.size() <= 144 || cap[144] !== ((d == 1) ? 1'b1 : 1'b0))
                $display("FAIL parity_bit dut%0d: len %0d, want bit %0d", d, cap.size(),
                         (d == 1) ? 1 : 0);
            else n_pass++;
        end
        n_checks++;
        if (cap.size() != 176) $display("FAIL parity_len: %0d ticks, want 176", cap.size());
        else n_pass++;
    endtask

    task automatic test_stop_len();
        int df, ones, spur;
        build_exp(1, 8'h00);
        kick(1, 8'h00);
        collect(1, 186, 8'hFF, 1'b0, 8'h00);
        df = frame_diff();
        n_checks++;
        if (!got_done || df !== -1)
            $display("FAIL stop_frame: done %b diff %0d, want 1 and -1", got_done, df);
        else n_pass++;
        ones = 0;
        for (int i = cap.size() - 1; i >= 0 && cap[i] === 1'b1; i--) ones++;
        n_checks++;
        if (ones != 32) $display("FAIL stop_high: %0d high ticks, want 32", ones);
        else n_pass++;
        spur = 0;
        repeat (300) begin
            @(negedge clk);
            if (busy_w[1] || done_w[1]) spur++;
        end
        n_checks++;
        if (spur != 0) $display("FAIL stop_early_start: %0d busy/done cycles, want 0", spur);
        else n_pass++;
    endtask

    task automatic test_random();
        int df;
        logic [7:0] v;
        for (int r = 0; r < 5; r++) begin
            for (int d = 0; d < 3; d++) begin
                repeat ($urandom_range(0, 20)) @(negedge clk);
                v = 8'($urandom);
                build_exp(d, v);
                kick(d, v);
                collect(d, -1, 8'h00, 1'b0, 8'h00);
                df = frame_diff();
                n_checks++;
                if (!got_done || df !== -1)
                    $display("FAIL random dut%0d data %02h: done %b diff %0d, want 1 and -1",
                             d, v, got_done, df);
                else n_pass++;
            end
        end
    endtask

    initial begin
        for (int d = 0; d < 3; d++) start_r[d] = 1'b0;
        test_reset();
        test_single();
        test_back_to_back();
        test_ignore_busy();
        test_reset_mid();
        test_parity();
        test_stop_len();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
